// File: rtl/fire_expand_ofm_collector.sv
// rtl/fire_expand_ofm_collector.sv - expand-layer ofm sink: capture DSP_NO words, serialise into layer RAM
// Optional build macro: OFM_OVERRUN_CHECK_EN (adds sticky overrun_err output)
module fire_expand_ofm_collector #(
  parameter int DSP_NO = 64,
  parameter int WIDTH  = 16,
  parameter int WOUT   = 64,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_en,
  input  logic              ofm_sample,
  input  logic [WIDTH-1:0]  ofm [0:DSP_NO-1],
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  output logic              ram_feedback,
`ifdef OFM_OVERRUN_CHECK_EN
  output logic              overrun_err,
`endif
  output logic              busy,
  output logic              done
);

  localparam int PIX_TOTAL = WOUT * WOUT;
  localparam int PW        = $clog2(PIX_TOTAL) + 1;
  localparam int CW        = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

  localparam logic [PW-1:0]     PIX_LAST = PW'(PIX_TOTAL);
  localparam logic [CW-1:0]     CH_LAST  = CW'(DSP_NO - 1);
  localparam logic [ADDR_W-1:0] DSP_A    = ADDR_W'(DSP_NO);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [PW-1:0]     pixel_cnt;
  logic [CW-1:0]     ch_cnt;
  logic [PW-1:0]     pixel_nxt;
  logic [CW-1:0]     ch_nxt;
  logic [WIDTH-1:0]  cap_buf [0:DSP_NO-1];
  logic              capture;

  assign pixel_nxt = pixel_cnt + PW'(1);
  assign ch_nxt    = ch_cnt + CW'(1);
  assign capture   = (state == S_IDLE) && layer_en && ofm_sample;

  // Capture buffer: holds the sampled words for the duration of the burst
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < DSP_NO; i++) begin
        cap_buf[i] <= ofm[i];
      end
    end
  end

  // Control FSM with registered RAM write port and status outputs;
  // word 0 is forwarded straight from ofm so the first write lands one cycle after capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pixel_cnt    <= '0;
      ch_cnt       <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_feedback <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      ram_feedback <= 1'b0;
      case (state)
        S_IDLE: begin
          ram_we <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
          if (!layer_en) begin
            pixel_cnt <= '0;
          end else if (ofm_sample) begin
            state     <= S_WRITE;
            ch_cnt    <= '0;
            ram_we    <= 1'b1;
            busy      <= 1'b1;
            ram_wdata <= ofm[0];
            ram_addr  <= ADDR_W'(pixel_cnt) * DSP_A;
          end
        end
        S_WRITE: begin
          if (!layer_en) begin
            // abort: drop the burst and all layer progress, no feedback
            state     <= S_IDLE;
            ram_we    <= 1'b0;
            busy      <= 1'b0;
            pixel_cnt <= '0;
            ch_cnt    <= '0;
          end else if (ch_cnt == CH_LAST) begin
            ram_we    <= 1'b0;
            busy      <= 1'b0;
            ch_cnt    <= '0;
            pixel_cnt <= pixel_nxt;
            if (pixel_nxt == PIX_LAST) begin
              state        <= S_DONE;
              done         <= 1'b1;
              ram_feedback <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            ch_cnt    <= ch_nxt;
            ram_wdata <= cap_buf[ch_nxt];
            ram_addr  <= ram_addr + ADDR_W'(1);
          end
        end
        S_DONE: begin
          // extra samples from the core are ignored until the layer is disarmed
          if (!layer_en) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            pixel_cnt <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef OFM_OVERRUN_CHECK_EN
  logic layer_en_q;

  // Sticky flag for samples arriving while a burst is still draining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_en_q  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      layer_en_q <= layer_en;
      if (layer_en_q && !layer_en) begin
        overrun_err <= 1'b0;
      end else if ((state == S_WRITE) && ofm_sample && layer_en) begin
        overrun_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fire_expand_ofm_collector.sv
// tb/tb_fire_expand_ofm_collector.sv - randomized self-checking bench for fire_expand_ofm_collector
module tb_fire_expand_ofm_collector;

  localparam int DSP_NO = 64;
  localparam int WIDTH  = 16;
  localparam int WOUT   = 4;
  localparam int ADDR_W = 18;
  localparam int NPIX   = WOUT * WOUT;
  localparam int NADDR  = NPIX * DSP_NO;

  logic              clk = 1'b0;
  logic              rst;
  logic              layer_en;
  logic              ofm_sample;
  logic [WIDTH-1:0]  ofm [0:DSP_NO-1];
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_wdata;
  logic              ram_feedback;
  logic              busy;
  logic              done;
`ifdef OFM_OVERRUN_CHECK_EN
  logic              overrun_err;
`endif

  fire_expand_ofm_collector #(
    .DSP_NO(DSP_NO), .WIDTH(WIDTH), .WOUT(WOUT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .layer_en(layer_en),
    .ofm_sample(ofm_sample),
    .ofm(ofm),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_feedback(ram_feedback),
`ifdef OFM_OVERRUN_CHECK_EN
    .overrun_err(overrun_err),
`endif
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: an accepted sample schedules DSP_NO writes on the following cycles;
  // the layer completes after NPIX full bursts.
  logic [ADDR_W+WIDTH-1:0] exp_q [$];
  int m_left = 0;
  int m_pix  = 0;
  bit m_done = 0;
  bit m_fb   = 0;
  bit m_ovr  = 0;

  task automatic model_reset();
    exp_q.delete();
    m_left = 0;
    m_pix  = 0;
    m_done = 0;
    m_fb   = 0;
    m_ovr  = 0;
  endtask

  always @(posedge clk) begin
    m_fb = 0;
    if (rst) begin
      model_reset();
    end else if (!layer_en) begin
      exp_q.delete();
      m_left = 0;
      m_pix  = 0;
      m_done = 0;
      m_ovr  = 0;
    end else if (m_left > 0) begin
      if (ofm_sample) m_ovr = 1;
      m_left--;
      if (m_left == 0) begin
        m_pix++;
        if (m_pix == NPIX) begin
          m_done = 1;
          m_fb   = 1;
        end
      end
    end else if (!m_done && ofm_sample) begin
      for (int i = 0; i < DSP_NO; i++)
        exp_q.push_back({ADDR_W'(m_pix * DSP_NO + i), ofm[i]});
      m_left = DSP_NO;
    end
  end

  // Scoreboard of actual writes for the full-layer coverage check
  bit collect = 0;
  int hits  [0:NADDR-1];
  logic [WIDTH-1:0] wdat [0:NADDR-1];
  int fb_cnt = 0;

  always @(negedge clk) begin
    logic [ADDR_W+WIDTH-1:0] e;
    if (!rst) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ram_we", 32'(ram_we), 32'd1);
        check("ram_addr", 32'(ram_addr), 32'(e[ADDR_W+WIDTH-1:WIDTH]));
        check("ram_wdata", 32'(ram_wdata), 32'(e[WIDTH-1:0]));
      end else begin
        check("ram_we_idle", 32'(ram_we), 32'd0);
      end
      check("busy", 32'(busy), 32'(m_left > 0));
      check("done", 32'(done), 32'(m_done));
      check("ram_feedback", 32'(ram_feedback), 32'(m_fb));
`ifdef OFM_OVERRUN_CHECK_EN
      check("overrun_err", 32'(overrun_err), 32'(m_ovr));
`endif
      if (collect) begin
        if (ram_we && ram_addr < ADDR_W'(NADDR)) begin
          hits[ram_addr]++;
          wdat[ram_addr] = ram_wdata;
        end
        if (ram_feedback) fb_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    ofm_sample = 1'b1;
    tick(1);
    ofm_sample = 1'b0;
  endtask

  task automatic rand_ofm();
    for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    layer_en = 1'b0;
    ofm_sample = 1'b0;
    for (int i = 0; i < DSP_NO; i++) ofm[i] = '0;
    model_reset();
    tick(3);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fb", 32'(ram_feedback), 32'd0);
    rst = 1'b0;
    tick(2);

    // single pixel with a fixed ramp
    layer_en = 1'b1;
    for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'(16'h0100 + i);
    pulse();
    tick(70);
    layer_en = 1'b0;
    tick(2);

    // full layer, ofm[i] = pixel*DSP_NO + i, samples 145 cycles apart
    for (int a = 0; a < NADDR; a++) hits[a] = 0;
    fb_cnt = 0;
    collect = 1;
    layer_en = 1'b1;
    for (int p = 0; p < NPIX; p++) begin
      for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'(p * DSP_NO + i);
      pulse();
      tick(144);
    end
    collect = 0;
    for (int a = 0; a < NADDR; a++) begin
      check("layer_hits", 32'(hits[a]), 32'd1);
      check("layer_data", 32'(wdat[a]), 32'(a));
    end
    check("layer_fb_count", 32'(fb_cnt), 32'd1);
    check("layer_done", 32'(done), 32'd1);

    // extra samples past the end of the layer
    repeat (3) begin
      rand_ofm();
      pulse();
      tick(20);
    end
    check("post_done_hold", 32'(done), 32'd1);
    layer_en = 1'b0;
    tick(2);
    layer_en = 1'b1;
    rand_ofm();
    pulse();
    tick(70);

    // overrun: second sample 10 cycles into the burst
    rand_ofm();
    pulse();
    tick(9);
    rand_ofm();
    pulse();
    tick(70);
    layer_en = 1'b0;
    tick(2);

    // abort at burst cycle 20, then restart from address 0
    layer_en = 1'b1;
    rand_ofm();
    pulse();
    tick(19);
    layer_en = 1'b0;
    tick(2);
    layer_en = 1'b1;
    rand_ofm();
    pulse();
    tick(70);

    // asynchronous reset pulse mid-burst
    rand_ofm();
    pulse();
    tick(30);
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_we", 32'(ram_we), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_fb", 32'(ram_feedback), 32'd0);
    #1;
    rst = 1'b0;
    tick(2);
    rand_ofm();
    pulse();
    tick(70);

    // randomized traffic: varied gaps (including overruns), occasional disarm
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 24) == 0) begin
        layer_en = 1'b0;
        tick($urandom_range(1, 3));
        layer_en = 1'b1;
      end
      rand_ofm();
      pulse();
      tick($urandom_range(0, 90));
    end
    layer_en = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fire_expand_ofm_collector.md
Name: fire_expand_ofm_collector

Overview:
- Sink end of the expand-layer output interface.
- Captures the DSP_NO parallel ofm words presented with each sample pulse, then serialises them into the layer output RAM, one word per cycle.
- Counts completed output pixels. After WOUT*WOUT pixels it returns the one-cycle ram_feedback pulse that the expand core uses to drop its finish flag.
- Sits between the fire expand 3x3 core and the feature-map RAM feeding the next squeeze layer.

Parameters:
- DSP_NO, 64, parallel output channels per sample.
- WIDTH, 16, ofm word width.
- WOUT, 64, output feature map side; WOUT*WOUT pixels per layer.
- ADDR_W, 18, RAM address width; must hold WOUT*WOUT*DSP_NO-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- layer_en  in  1  collector armed for the current layer; low clears progress
- ofm_sample  in  1  one-cycle pulse: ofm valid this cycle
- ofm  in  WIDTH x DSP_NO  unpacked array [0:DSP_NO-1] of output words
- ram_we  out  1  RAM write strobe
- ram_addr  out  ADDR_W  write address = pixel*DSP_NO + ch
- ram_wdata  out  WIDTH  write data
- ram_feedback  out  1  one-cycle pulse: full layer written
- busy  out  1  high in WRITE
- done  out  1  high in DONE

Behaviour:
- Reset (async, rst=1): state IDLE. pixel_cnt=0, ch_cnt=0. All outputs 0. Capture buffer contents don't-care.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - ofm_sample & layer_en at edge T: latch all DSP_NO words into the capture buffer, ch_cnt=0, go to WRITE.
  - ofm_sample with layer_en low: ignored.
- WRITE:
  - Registered outputs on cycles T+1 .. T+DSP_NO: ram_we=1, ram_wdata=buf[ch_cnt], ram_addr=pixel_cnt*DSP_NO+ch_cnt. ch_cnt increments each cycle.
  - Capture-to-first-write latency is 1 cycle; the burst is exactly DSP_NO cycles, back to back.
  - After the write with ch_cnt=DSP_NO-1: pixel_cnt increments.
    - New pixel_cnt == WOUT*WOUT: go to DONE.
    - Otherwise: go to IDLE.
  - ofm_sample during WRITE: not captured; the current burst continues unchanged. The expand core spaces samples 145 cycles apart, so this does not occur in normal operation.
- DONE:
  - ram_feedback=1 on the first DONE cycle only.
  - done=1 while in DONE.
  - All further ofm_sample pulses are ignored; the core emits extra pulses past WOUT^2.
  - layer_en low: go to IDLE, pixel_cnt=0.
- layer_en deasserted in WRITE: abort.
  - Next edge: ram_we=0, state IDLE, pixel_cnt=0, ch_cnt=0.
  - No ram_feedback.
- layer_en low in IDLE: pixel_cnt held at 0.
- Address arithmetic: unsigned, ADDR_W bits. The final address is WOUT*WOUT*DSP_NO-1 with no wrap. pixel_cnt has $clog2(WOUT*WOUT)+1 bits.
- Data: ram_wdata is ofm passed through unmodified; no saturation or ReLU.
- Reset asserted mid-burst: writes stop immediately (ram_we=0 asynchronously) and no feedback is produced.

Optional Feature:
- Macro: OFM_OVERRUN_CHECK_EN.
- Defined:
  - Adds output port overrun_err (1 bit), reset 0.
  - Sets sticky on any ofm_sample & layer_en received while in WRITE.
  - Cleared only by rst or a layer_en falling edge.
  - The dropped sample is still not captured.
- Undefined: port absent; samples during WRITE are silently dropped.

Test Plan:
- Single pixel: rst, layer_en=1, ofm[i]=16'h0100+i, one ofm_sample at T -> ram_we high T+1..T+64; addr 0..63; wdata 16'h0100..16'h013F; busy high for those 64 cycles; back to IDLE at T+65.
- Full layer, WOUT=4 override: 16 samples spaced 145 cycles, ofm[i]=pixel*64+i -> 1024 writes, addresses 0..1023 each written once with matching data; ram_feedback exactly one cycle after the last write; done held high.
- Post-done samples: 3 extra ofm_sample pulses after done -> no ram_we, no second ram_feedback; done stays 1 until layer_en=0, then pixel_cnt=0.
- Overrun with OFM_OVERRUN_CHECK_EN: second sample 10 cycles after the first -> first burst of 64 writes is unchanged; second sample data never written; overrun_err=1 until layer_en falls.
- Abort: layer_en dropped at burst cycle 20 -> ram_we=0 next cycle; re-enable and sample -> writes restart at addr 0.
- Async reset mid-burst: rst pulse between clock edges -> ram_we, busy, done, ram_feedback all 0 immediately; next sample writes at addr 0.
